seg_scan_ctrl: RTL

- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Sits directly upstream of the 8-input, 8-bit digit/segment mux.
- Drives the mux's 3-bit select and generates the matching active-low digit anodes and decimal point.
- Adds inter-digit dead time (anti-ghosting), per-digit blanking, per-digit blinking, and a frame-complete strobe.

---
 rtl/seg_scan_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// Drives the 3-bit digit select of the downstream digit/segment mux and
// generates the matching active-low anode and decimal-point controls. Each
// digit slot opens with a dead-time gap (all anodes off) to suppress ghosting.
// Per-digit blanking and blinking are applied, and a strobe marks every frame
// wrap.

module seg_scan_ctrl #(
    parameter int unsigned DIGIT_CYCLES = 1024,  // clk cycles per digit slot, >= 2
    parameter int unsigned DEAD_CYCLES  = 16,    // gap cycles at slot start, < DIGIT_CYCLES
    parameter int unsigned BLINK_FRAMES = 64     // frames per blink half-period, >= 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] blank_mask,
    input  logic [7:0] blink_mask,
    input  logic [7:0] dot_in,
    output logic [2:0] s,
    output logic [7:0] an,
    output logic       dp,
    output logic       frame_done
);

    localparam int unsigned CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] DEAD_END  = CW'(DEAD_CYCLES);
    localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_FRAMES - 1);

    typedef enum logic {PhGap, PhShow} phase_e;

    logic [CW-1:0] cnt_q;
    logic [2:0]    s_q;
    logic [FW-1:0] fcnt_q;
    logic          blink_phase_q;
    logic          frame_done_q;

    logic   slot_wrap;
    logic   frame_wrap;
    logic   blink_wrap;
    phase_e phase;
    logic   digit_lit;

    // Wrap events; en gates all of them so a disabled cycle never wraps.
    always_comb begin
        slot_wrap  = en && (cnt_q == CNT_LAST);
        frame_wrap = slot_wrap && (s_q == 3'd7);
        blink_wrap = frame_wrap && (fcnt_q == FCNT_LAST);
    end

    // Slot counter: counts enabled cycles within the current digit slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= slot_wrap ? '0 : cnt_q + 1'b1;
        end
    end

    // Digit select: advances at each slot wrap, 3-bit arithmetic wraps 7 -> 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 3'd0;
        end else if (slot_wrap) begin
            s_q <= s_q + 3'd1;
        end
    end

    // Frame counter and blink phase, both advanced only on frame wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q        <= '0;
            blink_phase_q <= 1'b0;
        end else if (frame_wrap) begin
            fcnt_q <= blink_wrap ? '0 : fcnt_q + 1'b1;
            if (blink_wrap) begin
                blink_phase_q <= ~blink_phase_q;
            end
        end
    end

    // Frame strobe: high in the first cycle with s=0 after a 7 -> 0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_wrap;
        end
    end

    // Slot phase: the first DEAD_CYCLES counts of a slot keep all anodes off.
    always_comb begin
        phase = (cnt_q < DEAD_END) ? PhGap : PhShow;
    end

    // Anode and decimal-point decode; rst_n is included so the display stays
    // dark for the whole reset even if the gap were zero-length.
    always_comb begin
        digit_lit = rst_n && en && (phase == PhShow) && !blank_mask[s_q]
                    && !(blink_mask[s_q] && blink_phase_q);
        an = 8'hFF;
        if (digit_lit) begin
            an[s_q] = 1'b0;
        end
        dp = 1'b1;
        if (!an[s_q] && dot_in[s_q]) begin
            dp = 1'b0;
        end
    end

    // Output drive; the strobe is suppressed while scanning is disabled.
    always_comb begin
        s          = s_q;
        frame_done = frame_done_q && en;
    end

endmodule
